// File: rtl/count_seq_ctrl_pkg.sv
// Shared state encodings and default sizing for the
// count sequencer and its prescaler.
package count_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_REP_W = 4;
  localparam int DEF_DIV   = 2;

endpackage

// File: rtl/count_seq_ctrl_tick_gen.sv
// Prescaler: wraps 0..DIV-1 while enabled and flags
// the last slot as the count-enable tick.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_q <= '0;
    end else if (en) begin
      if (div_q == LAST) div_q <= '0;
      else               div_q <= div_q + 1'b1;
    end
  end

  assign tick = en && (div_q == LAST);

endmodule

// File: rtl/count_seq_ctrl.sv
// Start/stop sequencer for the event counter: prescaled
// counting to a terminal value, repeat passes, auto-reload.
module count_seq_ctrl
  import count_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REP_W = DEF_REP_W,
  parameter int DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] term_val,
  input  logic [REP_W-1:0] rep_num,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt,
  output logic             tick,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] term_q;
  logic [REP_W-1:0] pass_q;
  logic [REP_W-1:0] rep_q;
  logic             auto_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             tick_w;
  logic             run_w;

  assign run_w = (state_q == ST_RUN);

  tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (run_w),
    .clr  (!run_w),
    .tick (tick_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      term_q  <= '0;
      pass_q  <= '0;
      rep_q   <= '0;
      auto_q  <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cout_q <= 1'b0;
          done_q <= 1'b0;
          if (start && !stop) begin
            term_q  <= term_val;
            rep_q   <= rep_num;
            auto_q  <= auto_reload;
            cnt_q   <= '0;
            pass_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          cout_q <= 1'b0;
          if (stop) begin
            // abort beats a coincident terminal tick
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (tick_w) begin
            if (cnt_q == term_q) begin
              cnt_q  <= '0;
              cout_q <= 1'b1;
              if (pass_q == rep_q && !auto_q) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else if (pass_q == rep_q) begin
                pass_q <= '0;
              end else begin
                pass_q <= pass_q + 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          cout_q  <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          cout_q  <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cnt  = cnt_q;
  assign tick = tick_w;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl at DIV=1 and DIV=2,
// checked cycle by cycle against a queue of expected outputs.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start2;
  logic       stop;
  logic [3:0] term_val;
  logic [3:0] rep_num;
  logic       auto_reload;

  logic [3:0] cnt1, cnt2;
  logic       tick1, tick2;
  logic       cout1, cout2;
  logic       busy1, busy2;
  logic       done1, done2;

  always #5 clk = ~clk;

  count_seq_ctrl #(.WIDTH(4), .REP_W(4), .DIV(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop),
    .term_val(term_val), .rep_num(rep_num),
    .auto_reload(auto_reload), .cnt(cnt1), .tick(tick1),
    .cout(cout1), .busy(busy1), .done(done1)
  );

  count_seq_ctrl #(.WIDTH(4), .REP_W(4), .DIV(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop),
    .term_val(term_val), .rep_num(rep_num),
    .auto_reload(auto_reload), .cnt(cnt2), .tick(tick2),
    .cout(cout2), .busy(busy2), .done(done2)
  );

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [7:0] pk(int c, bit co, bit b,
                                    bit d, bit t);
    return {4'(c), co, b, d, t};
  endfunction

  task automatic push(string tag, logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  // sel 0 -> DIV=1 instance, sel 1 -> DIV=2 instance
  task automatic check_one(int sel);
    exp_t       e;
    logic [7:0] obs;
    if (q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty: got 0 entries want 1");
      return;
    end
    e = q.pop_front();
    if (sel == 0) obs = {cnt1, cout1, busy1, done1, tick1};
    else          obs = {cnt2, cout2, busy2, done2, tick2};
    n_cmp++;
    assert (obs === e.v) else begin
      n_err++;
      $error("FAIL %s: got {cnt,cout,busy,done,tick}=%h want %h",
             e.tag, obs, e.v);
    end
  endtask

  task automatic set_start(int sel, bit v);
    if (sel == 0) start1 = v;
    else          start2 = v;
  endtask

  // Normal sequence; expectations come from the closed-form
  // timeline: cnt steps every div clks, done at (t+1)(r+1)div.
  task automatic run_seq(string nm, int sel, int div, int term,
                         int rep, bit disturb);
    int n;
    n = (term + 1) * (rep + 1) * div;
    term_val    = 4'(term);
    rep_num     = 4'(rep);
    auto_reload = 1'b0;
    for (int j = 0; j <= n + 1; j++) begin
      if (j < n)
        push($sformatf("%s_j%0d", nm, j),
             pk((j / div) % (term + 1),
                (j > 0) && (j % ((term + 1) * div) == 0),
                1'b1, 1'b0, (j % div) == div - 1));
      else if (j == n)
        push($sformatf("%s_done", nm), pk(0, 1, 0, 1, 0));
      else
        push($sformatf("%s_idle", nm), pk(0, 0, 0, 0, 0));
    end
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    for (int j = 0; j <= n + 1; j++) begin
      check_one(sel);
      if (disturb && j == 2) begin
        term_val = 4'd9;
        rep_num  = 4'd5;
        set_start(sel, 1'b1);
      end
      if (disturb && j == 3) set_start(sel, 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; stop = 1'b0;
    term_val = 4'd0; rep_num = 4'd0; auto_reload = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    push("reset_div1", pk(0, 0, 0, 0, 0));
    push("reset_div2", pk(0, 0, 0, 0, 0));
    check_one(0);
    check_one(1);
    rst = 1'b0;
    @(negedge clk);

    run_seq("single", 1, 2, 3, 0, 1'b0);
    run_seq("repeat", 1, 2, 3, 1, 1'b0);
    run_seq("full", 0, 1, 15, 0, 1'b0);
    run_seq("midchg", 1, 2, 3, 0, 1'b1);

    // start and stop together in IDLE: stop wins
    term_val = 4'd3; rep_num = 4'd0;
    start2 = 1'b1; stop = 1'b1;
    @(negedge clk);
    start2 = 1'b0; stop = 1'b0;
    push("startstop_a", pk(0, 0, 0, 0, 0));
    push("startstop_b", pk(0, 0, 0, 0, 0));
    check_one(1);
    @(negedge clk);
    check_one(1);
    @(negedge clk);

    // auto-reload, term 0: cout every tick, never done
    term_val = 4'd0; rep_num = 4'd0; auto_reload = 1'b1;
    push("auto_j0", pk(0, 0, 1, 0, 1));
    for (int j = 1; j <= 5; j++)
      push($sformatf("auto_j%0d", j), pk(0, 1, 1, 0, 1));
    push("auto_stop", pk(0, 0, 0, 0, 0));
    push("auto_after", pk(0, 0, 0, 0, 0));
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    auto_reload = 1'b0;
    for (int j = 0; j <= 7; j++) begin
      check_one(0);
      stop = (j == 5);
      @(negedge clk);
    end
    stop = 1'b0;

    // reset mid-run at cnt=7
    term_val = 4'd15; rep_num = 4'd0; auto_reload = 1'b0;
    for (int j = 0; j <= 14; j++)
      push($sformatf("rstrun_j%0d", j),
           pk(j / 2, 0, 1, 0, (j % 2) == 1));
    push("rstrun_rst", pk(0, 0, 0, 0, 0));
    push("rstrun_after", pk(0, 0, 0, 0, 0));
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      check_one(1);
      rst = (j == 14);
      @(negedge clk);
    end
    rst = 1'b0;

    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_left: got %0d entries want 0",
             q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
